axi4_mmio_slave_mem: RTL and testbench

- AXI4 (full) slave responder for the SoC's 64-bit MMIO master port (4-bit IDs, 30-bit addresses).
- Backed by an internal word-addressed memory; used as an FPGA-side MMIO scratch/mailbox target and as the bench endpoint for the core's MMIO traffic.
- Read and write channels run independently, each with one outstanding burst.
- Decodes a base/size window and returns DECERR for addresses outside it.

---
 rtl/axi4_mmio_slave_mem_if.sv | 52 +++++
 rtl/axi4_mmio_slave_mem.sv | 183 ++++++++++++++++++
 tb/tb_axi4_mmio_slave_mem.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_mmio_slave_mem_if.sv
// AXI4 bus bundle for the MMIO scratch/mailbox slave: 4-bit IDs, 30-bit byte
// addresses, 64-bit data. Clock and reset stay outside the bundle.
interface axi4_mmio_slave_mem_if;
  logic        AWVALID, AWREADY;
  logic [3:0]  AWID;
  logic [29:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWLOCK;
  logic [3:0]  AWCACHE;
  logic [2:0]  AWPROT;
  logic [3:0]  AWQOS;
  logic        WVALID, WREADY;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;
  logic        WLAST;
  logic        BVALID, BREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        ARVALID, ARREADY;
  logic [3:0]  ARID;
  logic [29:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARLOCK;
  logic [3:0]  ARCACHE;
  logic [2:0]  ARPROT;
  logic [3:0]  ARQOS;
  logic        RVALID, RREADY;
  logic [3:0]  RID;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;

  modport master (
    output AWVALID, AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS,
    output WVALID, WDATA, WSTRB, WLAST, BREADY,
    output ARVALID, ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS,
    output RREADY,
    input  AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RVALID, RID, RDATA, RRESP, RLAST
  );

  modport slave (
    input  AWVALID, AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS,
    input  WVALID, WDATA, WSTRB, WLAST, BREADY,
    input  ARVALID, ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS,
    input  RREADY,
    output AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RVALID, RID, RDATA, RRESP, RLAST
  );
endinterface

// File: rtl/axi4_mmio_slave_mem.sv
// AXI4 slave backed by a 64-bit word memory. Independent read and write
// channels, one burst outstanding each; DECERR outside the window, SLVERR on bad bursts.
module axi4_mmio_slave_mem #(
  parameter logic [29:0] BASE_ADDR = 30'h0000_0000,
  parameter int          DEPTH     = 512
) (
  input logic                  S_AXI_ACLK,
  input logic                  S_AXI_ARESETN,
  axi4_mmio_slave_mem_if.slave s_axi
);
  localparam int          IW   = $clog2(DEPTH);
  localparam logic [29:0] SPAN = 30'(DEPTH * 8);
  localparam logic [1:0]  OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
  localparam logic [1:0]  W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2;
  localparam logic [0:0]  R_IDLE = 1'b0, R_DATA = 1'b1;

  function automatic logic in_win(input logic [29:0] a);
    logic [30:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    return !off[30] && (off[29:0] < SPAN);
  endfunction

  function automatic logic [1:0] beat_code(input logic [29:0] a, input logic [2:0] sz,
                                           input logic [1:0] bt);
    if (!in_win(a)) return DECERR;
    if (sz > 3'd3 || bt[1]) return SLVERR;
    return OKAY;
  endfunction

  function automatic logic [29:0] next_addr(input logic [29:0] a, input logic [2:0] sz,
                                            input logic [1:0] bt);
    return (bt == 2'b01) ? a + (30'd1 << sz) : a;
  endfunction

  logic [63:0] mem [DEPTH];
  logic        rdy_q;

  // READYs stay low through reset and rise on the first cycle out of it
  always_ff @(posedge S_AXI_ACLK) rdy_q <= S_AXI_ARESETN;

  // ---------------- write channel ----------------
  logic [1:0]  wstate_q, wstate_d;
  logic [3:0]  wid_q;
  logic [29:0] waddr_q;
  logic [7:0]  wlen_q, wcnt_q;
  logic [2:0]  wsize_q;
  logic [1:0]  wburst_q, bresp_q, w_code, wb_code;
  logic        aw_hs, w_hs, w_last, w_en;

  assign s_axi.AWREADY = rdy_q && (wstate_q == W_IDLE);
  assign s_axi.WREADY  = (wstate_q == W_DATA);
  assign s_axi.BVALID  = (wstate_q == W_RESP);
  assign s_axi.BID     = wid_q;
  assign s_axi.BRESP   = bresp_q;

  assign aw_hs   = s_axi.AWVALID && s_axi.AWREADY;
  assign w_hs    = s_axi.WVALID && s_axi.WREADY;
  assign w_last  = (wcnt_q == wlen_q);
  assign w_code  = beat_code(waddr_q, wsize_q, wburst_q);
  // a misplaced WLAST flags the burst but the beat data is still stored
  assign wb_code = (s_axi.WLAST != w_last && w_code == OKAY) ? SLVERR : w_code;
  assign w_en    = w_hs && (w_code == OKAY) && S_AXI_ARESETN;

  always_comb begin
    wstate_d = wstate_q;
    case (wstate_q)
      W_IDLE:  if (aw_hs) wstate_d = W_DATA;
      W_DATA:  if (w_hs && w_last) wstate_d = W_RESP;
      W_RESP:  if (s_axi.BREADY) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      wstate_q <= W_IDLE;
      wid_q    <= '0;
      waddr_q  <= '0;
      wlen_q   <= '0;
      wcnt_q   <= '0;
      wsize_q  <= '0;
      wburst_q <= '0;
      bresp_q  <= OKAY;
    end else begin
      wstate_q <= wstate_d;
      if (aw_hs) begin
        wid_q    <= s_axi.AWID;
        waddr_q  <= s_axi.AWADDR;
        wlen_q   <= s_axi.AWLEN;
        wsize_q  <= s_axi.AWSIZE;
        wburst_q <= s_axi.AWBURST;
        wcnt_q   <= '0;
        bresp_q  <= OKAY;
      end
      if (w_hs) begin
        waddr_q <= next_addr(waddr_q, wsize_q, wburst_q);
        wcnt_q  <= wcnt_q + 8'd1;
        if (wb_code > bresp_q) bresp_q <= wb_code;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (w_en)
      for (int i = 0; i < 8; i++)
        if (s_axi.WSTRB[i]) mem[waddr_q[IW+2:3]][8*i +: 8] <= s_axi.WDATA[8*i +: 8];
  end

  // ---------------- read channel ----------------
  logic [0:0]  rstate_q, rstate_d;
  logic [3:0]  rid_q;
  logic [29:0] raddr_q, r_nxt, ld_addr;
  logic [7:0]  rlen_q, rcnt_q;
  logic [2:0]  rsize_q, ld_size;
  logic [1:0]  rburst_q, ld_burst, ld_code, rresp_q;
  logic [63:0] rdata_q;
  logic        rlast_q, ar_hs, r_adv;

  assign s_axi.ARREADY = rdy_q && (rstate_q == R_IDLE);
  assign s_axi.RVALID  = (rstate_q == R_DATA);
  assign s_axi.RID     = rid_q;
  assign s_axi.RDATA   = rdata_q;
  assign s_axi.RRESP   = rresp_q;
  assign s_axi.RLAST   = rlast_q;

  assign ar_hs = s_axi.ARVALID && s_axi.ARREADY;
  assign r_adv = s_axi.RVALID && s_axi.RREADY && !rlast_q;
  assign r_nxt = next_addr(raddr_q, rsize_q, rburst_q);

  // the beat being loaded is either the first of a new burst or the successor
  assign ld_addr  = ar_hs ? s_axi.ARADDR  : r_nxt;
  assign ld_size  = ar_hs ? s_axi.ARSIZE  : rsize_q;
  assign ld_burst = ar_hs ? s_axi.ARBURST : rburst_q;
  assign ld_code  = beat_code(ld_addr, ld_size, ld_burst);

  always_comb begin
    rstate_d = rstate_q;
    case (rstate_q)
      R_IDLE:  if (ar_hs) rstate_d = R_DATA;
      R_DATA:  if (s_axi.RREADY && rlast_q) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      rstate_q <= R_IDLE;
      rid_q    <= '0;
      raddr_q  <= '0;
      rlen_q   <= '0;
      rcnt_q   <= '0;
      rsize_q  <= '0;
      rburst_q <= '0;
      rdata_q  <= '0;
      rresp_q  <= OKAY;
      rlast_q  <= 1'b0;
    end else begin
      rstate_q <= rstate_d;
      if (ar_hs) begin
        rid_q    <= s_axi.ARID;
        raddr_q  <= s_axi.ARADDR;
        rlen_q   <= s_axi.ARLEN;
        rsize_q  <= s_axi.ARSIZE;
        rburst_q <= s_axi.ARBURST;
        rcnt_q   <= '0;
        rlast_q  <= (s_axi.ARLEN == 8'd0);
      end else if (r_adv) begin
        raddr_q <= r_nxt;
        rcnt_q  <= rcnt_q + 8'd1;
        rlast_q <= ((rcnt_q + 8'd1) == rlen_q);
      end
      // memory is sampled before this edge's write lands, so a colliding read sees old data
      if (ar_hs || r_adv) begin
        rdata_q <= (ld_code == OKAY) ? mem[ld_addr[IW+2:3]] : '0;
        rresp_q <= ld_code;
      end
    end
  end

  logic unused_sideband;
  assign unused_sideband = ^{s_axi.AWLOCK, s_axi.AWCACHE, s_axi.AWPROT, s_axi.AWQOS,
                             s_axi.ARLOCK, s_axi.ARCACHE, s_axi.ARPROT, s_axi.ARQOS};
endmodule

// File: tb/tb_axi4_mmio_slave_mem.sv
// Directed bench for axi4_mmio_slave_mem: reset, bursts, strobes, error codes,
// channel concurrency and reset in the middle of a read burst.
module tb_axi4_mmio_slave_mem;
  logic clk, rstn;
  int checks = 0;
  int errors = 0;

  axi4_mmio_slave_mem_if bus ();

  axi4_mmio_slave_mem #(.BASE_ADDR(30'h0), .DEPTH(512)) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESETN(rstn),
    .s_axi(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] wbuf  [0:15];
  logic [63:0] rdat  [0:15];
  logic [1:0]  rresp_a [0:15];
  int          rcyc  [0:15];
  logic [15:0] rlast_a;
  logic [3:0]  rid_a;
  int          nbeats;
  logic        stable_ok;

  task automatic do_write(input logic [3:0] id, input logic [29:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [7:0] strb,
                          input logic early_last, output logic [3:0] bid, output logic [1:0] bresp);
    int n;
    bid = 'x; bresp = 'x;
    bus.AWVALID = 1; bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len;
    bus.AWSIZE = size; bus.AWBURST = burst;
    n = 0; @(negedge clk);
    while (!bus.AWREADY && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1 bus.AWVALID = 0;
    for (int b = 0; b <= int'(len); b++) begin
      bus.WVALID = 1; bus.WDATA = wbuf[b]; bus.WSTRB = strb;
      bus.WLAST = early_last ? (b == 0) : (b == int'(len));
      n = 0; @(negedge clk);
      while (!bus.WREADY && n < 50) begin @(negedge clk); n++; end
      @(posedge clk); #1;
    end
    bus.WVALID = 0; bus.WLAST = 0; bus.BREADY = 1;
    n = 0; @(negedge clk);
    while (!bus.BVALID && n < 50) begin @(negedge clk); n++; end
    if (bus.BVALID) begin bid = bus.BID; bresp = bus.BRESP; end
    @(posedge clk); #1 bus.BREADY = 0;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [29:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic toggle);
    int n, cyc, b;
    logic held;
    logic [66:0] hd;
    for (int i = 0; i < 16; i++) begin rdat[i] = 'x; rresp_a[i] = 'x; rcyc[i] = -1; end
    rlast_a = '0; rid_a = 'x; stable_ok = 1;
    bus.ARVALID = 1; bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len;
    bus.ARSIZE = size; bus.ARBURST = burst;
    n = 0; @(negedge clk);
    while (!bus.ARREADY && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1 bus.ARVALID = 0;
    cyc = 0; b = 0; held = 0; hd = '0;
    while (b <= int'(len) && cyc < 100) begin
      bus.RREADY = toggle ? (cyc % 2 == 0) : 1'b1;
      @(negedge clk);
      if (bus.RVALID) begin
        if (held && {bus.RDATA, bus.RRESP, bus.RLAST} !== hd) stable_ok = 0;
        if (bus.RREADY) begin
          rdat[b] = bus.RDATA; rresp_a[b] = bus.RRESP; rlast_a[b] = bus.RLAST;
          rcyc[b] = cyc; rid_a = bus.RID; b++; held = 0;
        end else begin
          held = 1; hd = {bus.RDATA, bus.RRESP, bus.RLAST};
        end
      end else if (held) stable_ok = 0;
      @(posedge clk); #1; cyc++;
    end
    bus.RREADY = 0; nbeats = b;
  endtask

  task automatic test_reset();
    rstn = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.AWREADY, bus.WREADY, bus.BVALID, bus.ARREADY, bus.RVALID} !== 5'b0) begin
      errors++;
      $display("FAIL reset_rdy_vld: got %b exp 00000",
               {bus.AWREADY, bus.WREADY, bus.BVALID, bus.ARREADY, bus.RVALID});
    end
    checks++;
    if ({bus.BID, bus.BRESP, bus.RID, bus.RDATA, bus.RRESP, bus.RLAST} !== 77'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %h exp 0",
               {bus.BID, bus.BRESP, bus.RID, bus.RDATA, bus.RRESP, bus.RLAST});
    end
    @(posedge clk); #1 rstn = 1;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({bus.AWREADY, bus.ARREADY} !== 2'b11) begin
      errors++; $display("FAIL reset_release_ready: got %b exp 11", {bus.AWREADY, bus.ARREADY});
    end
  endtask

  task automatic test_single();
    logic [3:0] bid; logic [1:0] br;
    wbuf[0] = 64'h0123_4567_89AB_CDEF;
    do_write(4'h5, 30'h10, 8'd0, 3'd3, 2'b01, 8'hFF, 1'b0, bid, br);
    checks++;
    if ({bid, br} !== {4'h5, 2'b00}) begin
      errors++; $display("FAIL single_bresp: got bid=%h bresp=%b exp bid=5 bresp=00", bid, br);
    end
    @(negedge clk);
    checks++;
    if ({bus.AWREADY, bus.BVALID} !== 2'b10) begin
      errors++; $display("FAIL single_aw_reopen: got %b exp 10", {bus.AWREADY, bus.BVALID});
    end
    do_read(4'h9, 30'h10, 8'd0, 3'd3, 2'b01, 1'b0);
    checks++;
    if (rdat[0] !== 64'h0123_4567_89AB_CDEF) begin
      errors++; $display("FAIL single_rdata: got %h exp 0123456789abcdef", rdat[0]);
    end
    checks++;
    if ({rid_a, rresp_a[0], rlast_a[0]} !== {4'h9, 2'b00, 1'b1}) begin
      errors++; $display("FAIL single_rctl: got rid=%h rresp=%b rlast=%b exp 9/00/1",
                         rid_a, rresp_a[0], rlast_a[0]);
    end
    checks++;
    if (rcyc[0] !== 0) begin
      errors++; $display("FAIL single_latency: got %0d exp 0 cycles after AR", rcyc[0]);
    end
    @(negedge clk);
    checks++;
    if ({bus.ARREADY, bus.RVALID} !== 2'b10) begin
      errors++; $display("FAIL single_ar_reopen: got %b exp 10", {bus.ARREADY, bus.RVALID});
    end
  endtask

  task automatic test_incr_burst();
    logic [3:0] bid; logic [1:0] br;
    for (int i = 0; i < 4; i++) wbuf[i] = 64'(i + 1);
    do_write(4'h2, 30'h20, 8'd3, 3'd3, 2'b01, 8'hFF, 1'b0, bid, br);
    checks++;
    if (br !== 2'b00) begin errors++; $display("FAIL incr_bresp: got %b exp 00", br); end
    do_read(4'h3, 30'h20, 8'd3, 3'd3, 2'b01, 1'b1);
    checks++;
    if ({rdat[0], rdat[1], rdat[2], rdat[3]} !== {64'd1, 64'd2, 64'd3, 64'd4}) begin
      errors++; $display("FAIL incr_toggle_data: got %h %h %h %h exp 1 2 3 4",
                         rdat[0], rdat[1], rdat[2], rdat[3]);
    end
    checks++;
    if ({rlast_a[3:0], stable_ok} !== 5'b1000_1) begin
      errors++; $display("FAIL incr_toggle_last_stable: got rlast=%b stable=%b exp 1000/1",
                         rlast_a[3:0], stable_ok);
    end
    checks++;
    if (rcyc[3] !== 6) begin errors++; $display("FAIL incr_toggle_timing: got %0d exp 6", rcyc[3]); end
    do_read(4'h3, 30'h20, 8'd3, 3'd3, 2'b01, 1'b0);
    checks++;
    if ({rdat[0], rdat[1], rdat[2], rdat[3]} !== {64'd1, 64'd2, 64'd3, 64'd4} || nbeats != 4) begin
      errors++; $display("FAIL incr_b2b_data: got %h %h %h %h beats=%0d exp 1 2 3 4 beats=4",
                         rdat[0], rdat[1], rdat[2], rdat[3], nbeats);
    end
    checks++;
    if (rcyc[3] !== 3) begin errors++; $display("FAIL incr_b2b_timing: got %0d exp 3", rcyc[3]); end
  endtask

  task automatic test_strobe_fixed();
    logic [3:0] bid; logic [1:0] br;
    wbuf[0] = 64'h0;
    do_write(4'h1, 30'h40, 8'd0, 3'd3, 2'b01, 8'hFF, 1'b0, bid, br);
    wbuf[0] = '1;
    do_write(4'h1, 30'h40, 8'd0, 3'd3, 2'b01, 8'h0F, 1'b0, bid, br);
    do_read(4'h1, 30'h40, 8'd0, 3'd3, 2'b01, 1'b0);
    checks++;
    if (rdat[0] !== 64'h0000_0000_FFFF_FFFF) begin
      errors++; $display("FAIL strobe_data: got %h exp 00000000ffffffff", rdat[0]);
    end
    wbuf[0] = 64'h5050;
    do_write(4'h1, 30'h50, 8'd0, 3'd3, 2'b01, 8'hFF, 1'b0, bid, br);
    wbuf[0] = 64'hA; wbuf[1] = 64'hB; wbuf[2] = 64'hC;
    do_write(4'h6, 30'h48, 8'd2, 3'd3, 2'b00, 8'hFF, 1'b0, bid, br);
    checks++;
    if (br !== 2'b00) begin errors++; $display("FAIL fixed_bresp: got %b exp 00", br); end
    do_read(4'h1, 30'h48, 8'd1, 3'd3, 2'b01, 1'b0);
    checks++;
    if ({rdat[0], rdat[1]} !== {64'hC, 64'h5050}) begin
      errors++; $display("FAIL fixed_data: got %h %h exp c 5050", rdat[0], rdat[1]);
    end
  endtask

  task automatic test_errors();
    logic [3:0] bid; logic [1:0] br;
    wbuf[0] = 64'h5555_5555_5555_5555;
    do_write(4'h1, 30'h0, 8'd0, 3'd3, 2'b01, 8'hFF, 1'b0, bid, br);
    wbuf[0] = 64'hDEAD;
    do_write(4'h3, 30'h1000, 8'd0, 3'd3, 2'b01, 8'hFF, 1'b0, bid, br);
    checks++;
    if ({bid, br} !== {4'h3, 2'b11}) begin
      errors++; $display("FAIL decerr_bresp: got bid=%h bresp=%b exp 3/11", bid, br);
    end
    do_read(4'h1, 30'h0, 8'd0, 3'd3, 2'b01, 1'b0);
    checks++;
    if (rdat[0] !== 64'h5555_5555_5555_5555) begin
      errors++; $display("FAIL decerr_mem_kept: got %h exp 5555555555555555", rdat[0]);
    end
    do_read(4'h4, 30'h1000, 8'd0, 3'd3, 2'b01, 1'b0);
    checks++;
    if ({rdat[0], rresp_a[0], rlast_a[0]} !== {64'h0, 2'b11, 1'b1}) begin
      errors++; $display("FAIL decerr_read: got data=%h rresp=%b rlast=%b exp 0/11/1",
                         rdat[0], rresp_a[0], rlast_a[0]);
    end
    wbuf[0] = 64'h6060;
    do_write(4'h1, 30'h60, 8'd0, 3'd3, 2'b01, 8'hFF, 1'b0, bid, br);
    wbuf[0] = 64'hBAD;
    do_write(4'h7, 30'h60, 8'd0, 3'd3, 2'b10, 8'hFF, 1'b0, bid, br);
    checks++;
    if (br !== 2'b10) begin errors++; $display("FAIL wrap_bresp: got %b exp 10", br); end
    do_read(4'h1, 30'h60, 8'd0, 3'd3, 2'b01, 1'b0);
    checks++;
    if (rdat[0] !== 64'h6060) begin
      errors++; $display("FAIL wrap_dropped: got %h exp 6060", rdat[0]);
    end
    wbuf[0] = 64'h71; wbuf[1] = 64'h72;
    do_write(4'h8, 30'h70, 8'd1, 3'd3, 2'b01, 8'hFF, 1'b1, bid, br);
    checks++;
    if (br !== 2'b10) begin errors++; $display("FAIL early_wlast_bresp: got %b exp 10", br); end
    do_read(4'h1, 30'h70, 8'd1, 3'd3, 2'b01, 1'b0);
    checks++;
    if ({rdat[0], rdat[1]} !== {64'h71, 64'h72}) begin
      errors++; $display("FAIL early_wlast_data: got %h %h exp 71 72", rdat[0], rdat[1]);
    end
    do_read(4'h2, 30'h10, 8'd1, 3'd4, 2'b01, 1'b0);
    checks++;
    if ({rdat[0], rdat[1], rresp_a[0], rresp_a[1], rlast_a[1:0]} !== {128'h0, 4'b1010, 2'b10} ||
        nbeats != 2) begin
      errors++; $display("FAIL badsize_read: got %h %h resp=%b%b last=%b beats=%0d exp 0 0 1010 10 2",
                         rdat[0], rdat[1], rresp_a[0], rresp_a[1], rlast_a[1:0], nbeats);
    end
  endtask

  task automatic test_concurrent();
    logic [3:0] bid; logic [1:0] br;
    logic ok0, v1, l1, bv;
    logic [63:0] d0, d1;
    logic [1:0] bres;
    int n;
    wbuf[0] = 64'h0A0A_0A0A_0A0A_0A0A;
    do_write(4'h1, 30'h80, 8'd0, 3'd3, 2'b01, 8'hFF, 1'b0, bid, br);
    wbuf[0] = 64'h7878;
    do_write(4'h1, 30'h78, 8'd0, 3'd3, 2'b01, 8'hFF, 1'b0, bid, br);
    bus.AWVALID = 1; bus.AWID = 4'h1; bus.AWADDR = 30'h80; bus.AWLEN = 0;
    bus.AWSIZE = 3'd3; bus.AWBURST = 2'b01;
    bus.ARVALID = 1; bus.ARID = 4'h2; bus.ARADDR = 30'h78; bus.ARLEN = 8'd1;
    bus.ARSIZE = 3'd3; bus.ARBURST = 2'b01;
    n = 0; @(negedge clk);
    while (!(bus.AWREADY && bus.ARREADY) && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1 bus.AWVALID = 0; bus.ARVALID = 0;
    bus.WVALID = 1; bus.WDATA = 64'hFEED_FACE_0000_1111; bus.WSTRB = 8'hFF; bus.WLAST = 1;
    bus.RREADY = 1;
    @(negedge clk); ok0 = bus.WREADY && bus.RVALID; d0 = bus.RDATA;
    @(posedge clk); #1 bus.WVALID = 0; bus.WLAST = 0;
    @(negedge clk); v1 = bus.RVALID; d1 = bus.RDATA; l1 = bus.RLAST;
    @(posedge clk); #1 bus.RREADY = 0; bus.BREADY = 1;
    @(negedge clk); bv = bus.BVALID; bres = bus.BRESP;
    @(posedge clk); #1 bus.BREADY = 0;
    checks++;
    if ({ok0, v1, l1, bv, bres} !== 6'b1111_00) begin
      errors++; $display("FAIL concur_handshakes: got %b exp 111100", {ok0, v1, l1, bv, bres});
    end
    checks++;
    if ({d0, d1} !== {64'h7878, 64'h0A0A_0A0A_0A0A_0A0A}) begin
      errors++; $display("FAIL concur_old_data: got %h %h exp 7878 0a0a0a0a0a0a0a0a", d0, d1);
    end
    do_read(4'h1, 30'h80, 8'd0, 3'd3, 2'b01, 1'b0);
    checks++;
    if (rdat[0] !== 64'hFEED_FACE_0000_1111) begin
      errors++; $display("FAIL concur_new_data: got %h exp feedface00001111", rdat[0]);
    end
  endtask

  task automatic test_midburst_reset();
    logic pre, spurious;
    int n;
    bus.ARVALID = 1; bus.ARID = 4'h5; bus.ARADDR = 30'h0; bus.ARLEN = 8'd7;
    bus.ARSIZE = 3'd3; bus.ARBURST = 2'b01;
    n = 0; @(negedge clk);
    while (!bus.ARREADY && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1 bus.ARVALID = 0; bus.RREADY = 1;
    @(posedge clk);
    @(posedge clk); #1 rstn = 0;
    @(negedge clk); pre = bus.RVALID;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({pre, bus.RVALID, bus.ARREADY} !== 3'b100) begin
      errors++; $display("FAIL midreset_abort: got %b exp 100", {pre, bus.RVALID, bus.ARREADY});
    end
    @(posedge clk); #1 rstn = 1;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({bus.ARREADY, bus.RVALID} !== 2'b10) begin
      errors++; $display("FAIL midreset_release: got %b exp 10", {bus.ARREADY, bus.RVALID});
    end
    spurious = 0;
    repeat (5) begin @(negedge clk); if (bus.RVALID !== 1'b0) spurious = 1; end
    checks++;
    if (spurious !== 1'b0) begin
      errors++; $display("FAIL midreset_no_beats: got %b exp 0", spurious);
    end
    bus.RREADY = 0;
  endtask

  initial begin
    rstn = 0;
    bus.AWVALID = 0; bus.AWID = 0; bus.AWADDR = 0; bus.AWLEN = 0; bus.AWSIZE = 0; bus.AWBURST = 0;
    bus.AWLOCK = 0; bus.AWCACHE = 0; bus.AWPROT = 0; bus.AWQOS = 0;
    bus.WVALID = 0; bus.WDATA = 0; bus.WSTRB = 0; bus.WLAST = 0; bus.BREADY = 0;
    bus.ARVALID = 0; bus.ARID = 0; bus.ARADDR = 0; bus.ARLEN = 0; bus.ARSIZE = 0; bus.ARBURST = 0;
    bus.ARLOCK = 0; bus.ARCACHE = 0; bus.ARPROT = 0; bus.ARQOS = 0;
    bus.RREADY = 0;
    test_reset();
    test_single();
    test_incr_burst();
    test_strobe_fixed();
    test_errors();
    test_concurrent();
    test_midburst_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
